layer_2_featuremap_packer: RTL and testbench
============================================

Name: layer_2_featuremap_packer

Overview:
- Transmit-side producer for a layer-2 feature map stream.
- Collects per-channel 32-bit float pixel values arriving serially (channel 0 first).
- Packs NUM_CH of them into one wide word: lane c occupies bits [32c+31:32c].
- Emits the packed word with a valid/ready handshake on the same 512-bit, 16-lane bus the layer-2 Conv2D3x3 banks consume. Counts pixels per IMG_SIZE x IMG_SIZE frame and flags end of frame.

Parameters:
- DATA_WIDTH, 32, width of one channel value (IEEE-754 single).
- NUM_CH, 16, channels packed per output word.
- IMG_SIZE, 208, feature map width and height in pixels; frame = IMG_SIZE*IMG_SIZE words.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  one channel value.
- valid_in  in  1  data_in valid.
- ready_out  out  1  packer can accept data_in this cycle.
- data_out  out  NUM_CH*DATA_WIDTH  packed pixel, lane c = channel c.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts data_out.
- frame_done  out  1  one-cycle pulse on the output handshake of the last pixel of a frame.

Behaviour:
- Handshake events:
  - accept = valid_in & ready_out.
  - fire = valid_out & ready_in.
- State:
  - fill_reg: NUM_CH*DATA_WIDTH bits.
  - ch_cnt: 0..NUM_CH-1.
  - fill_full: 1 bit.
  - out_reg: drives data_out.
  - valid_out: 1 bit.
  - pix_cnt: 0..IMG_SIZE^2-1, width clog2(IMG_SIZE^2).
- Reset (Rst low, async): all of the following are 0 immediately, regardless of Clk:
  - state: ch_cnt, fill_full, fill_reg, out_reg, pix_cnt;
  - outputs: valid_out, frame_done.
  - ready_out then reads 1.
  - Partial fills and pending outputs are discarded.
- Definitions:
  - can_xfer = ~valid_out | ready_in.
  - ready_out = ~fill_full | can_xfer (combinational; ready_in-to-ready_out path permitted).
- On accept:
  - Lane ch_cnt of fill_reg <= data_in.
  - If ch_cnt == NUM_CH-1: ch_cnt <= 0 and fill_full <= 1. Otherwise ch_cnt increments.
- Transfer, when fill_full & can_xfer:
  - out_reg <= fill_reg; valid_out <= 1; fill_full <= 0.
  - Else if fire: valid_out <= 0.
  - Else valid_out and out_reg hold; data_out is stable while valid_out=1 and ready_in=0.
- Simultaneous accept and transfer:
  - Permitted. The old fill_reg contents go to out_reg; data_in is written into lane 0 of the new fill.
  - fill_full ends at 0; no lanes mix.
- Latency and throughput:
  - 16th accept at edge t -> fill_full=1 after t -> valid_out=1 after t+1, given can_xfer.
  - Sustained rate is one pixel per NUM_CH cycles, with no bubbles while ready_in=1.
- Backpressure:
  - With fill_full=1, valid_out=1 and ready_in=0, ready_out=0.
  - valid_in is ignored and nothing changes.
- Frame counting:
  - pix_cnt increments on every fire.
  - On a fire with pix_cnt == IMG_SIZE^2-1: pix_cnt <= 0 and frame_done = 1 for the next cycle only. Otherwise frame_done = 0.
  - Frames run back-to-back with no gap.
- valid_in gaps:
  - Allowed at any channel boundary; ch_cnt holds.
  - data_in is don't-care when valid_in=0.
- Unused lanes of fill_reg hold stale values until overwritten. data_out is only meaningful while valid_out=1.

Test Plan:
- Single pixel: IMG_SIZE=208, ready_in=1, feed 16 words 32'h3F800000+i back-to-back -> valid_out high 2 cycles after the last accept, for exactly 1 cycle; lane i = 32'h3F800000+i; ready_out stays 1.
- Backpressure: ready_in=0 while pixel A is valid and pixel B is fully filled -> ready_out=0 and data_out holds A. Raise ready_in for one cycle -> A fires, B appears the next cycle, ready_out returns to 1.
- Full throughput: IMG_SIZE=4, continuous valid_in and ready_in=1, 256 words -> 16 outputs spaced exactly 16 cycles apart. frame_done pulses once, 1 cycle after the 16th fire; pix_cnt is back at 0.
- Gapped input: valid_in toggled 1-0-1 with lane value 32'hDEADBEEF only on valid cycles -> correct lane ordering, no duplicated or dropped lanes.
- Mid-operation reset: assert Rst low after 7 accepts, deassert, then feed 16 words -> output contains only the post-reset words in lanes 0..15. valid_out and frame_done are 0 during reset.
- Wrap: IMG_SIZE=2, two consecutive frames -> frame_done pulses after fires 4 and 8; second-frame data is unaffected.

Source files
------------

// File: rtl/layer_2_featuremap_packer.sv
// -----------------------------------------------------------------------------
// layer_2_featuremap_packer
//
// Transmit-side producer for the layer-2 feature map stream. Channel values
// (one IEEE-754 single per beat, channel 0 first) are collected into a fill
// buffer. Once NUM_CH values are present they move to an output register and
// are offered on a wide valid/ready bus. Lane c of the bus carries channel c.
// Output handshakes are counted per IMG_SIZE x IMG_SIZE frame, and the last
// pixel of each frame raises a one-cycle frame_done pulse.
//
// The fill buffer and the output register form a two-deep pipeline. A new
// pixel can start filling while the previous one waits for the consumer.
// Input stalls only when both stages are occupied and the consumer is not
// ready.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous active-low reset
//   data_in    in   one channel value (DATA_WIDTH)
//   valid_in   in   data_in valid
//   ready_out  out  packer accepts data_in this cycle (combinational)
//   data_out   out  packed pixel, lane c = channel c (NUM_CH*DATA_WIDTH)
//   valid_out  out  data_out valid
//   ready_in   in   downstream accepts data_out
//   frame_done out  one-cycle pulse after the last pixel of a frame is taken
// -----------------------------------------------------------------------------
module layer_2_featuremap_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 16,
  parameter int IMG_SIZE   = 208
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         frame_done
);

  localparam int BUS_W     = NUM_CH * DATA_WIDTH;
  localparam int FRAME_PIX = IMG_SIZE * IMG_SIZE;
  localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIX - 1);

  // State registers and their next-state values
  logic [BUS_W-1:0] fill_q,       fill_d;
  logic [CH_W-1:0]  ch_cnt_q,     ch_cnt_d;
  logic             fill_full_q,  fill_full_d;
  logic [BUS_W-1:0] out_q,        out_d;
  logic             valid_q,      valid_d;
  logic [PIX_W-1:0] pix_cnt_q,    pix_cnt_d;
  logic             frame_done_q, frame_done_d;

  // Handshake qualifiers
  logic can_xfer_s;
  logic accept_s;
  logic fire_s;
  logic xfer_s;

  // The output register can take a new pixel if it is empty, or if its
  // current pixel is leaving this cycle.
  assign can_xfer_s = ~valid_q | ready_in;
  assign ready_out  = ~fill_full_q | can_xfer_s;
  assign accept_s   = valid_in & ready_out;
  assign fire_s     = valid_q & ready_in;
  assign xfer_s     = fill_full_q & can_xfer_s;

  assign data_out   = out_q;
  assign valid_out  = valid_q;
  assign frame_done = frame_done_q;

  // Write the incoming channel value into its lane of the fill buffer
  always_comb begin
    fill_d = fill_q;
    if (accept_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_cnt_q == CH_W'(c)) begin
          fill_d[c*DATA_WIDTH +: DATA_WIDTH] = data_in;
        end else begin
          fill_d[c*DATA_WIDTH +: DATA_WIDTH] = fill_q[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end else begin
      fill_d = fill_q;
    end
  end

  // Advance the channel counter and track when the fill buffer holds a full pixel
  always_comb begin
    ch_cnt_d    = ch_cnt_q;
    fill_full_d = fill_full_q;
    // A transfer empties the buffer first. An accept of the last lane in
    // the same cycle refills it. That case only arises when NUM_CH == 1,
    // because a full buffer always has ch_cnt == 0.
    if (xfer_s) begin
      fill_full_d = 1'b0;
    end else begin
      fill_full_d = fill_full_q;
    end
    if (accept_s) begin
      if (ch_cnt_q == LAST_CH) begin
        ch_cnt_d    = {CH_W{1'b0}};
        fill_full_d = 1'b1;
      end else begin
        ch_cnt_d    = ch_cnt_q + CH_W'(1);
      end
    end else begin
      ch_cnt_d = ch_cnt_q;
    end
  end

  // Load the output register from the fill buffer, or retire it on a handshake
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (xfer_s) begin
      out_d   = fill_q;
      valid_d = 1'b1;
    end else if (fire_s) begin
      out_d   = out_q;
      valid_d = 1'b0;
    end else begin
      out_d   = out_q;
      valid_d = valid_q;
    end
  end

  // Count output pixels within a frame and flag the last one
  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (fire_s) begin
      if (pix_cnt_q == LAST_PIX) begin
        pix_cnt_d    = {PIX_W{1'b0}};
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d    = pix_cnt_q + PIX_W'(1);
        frame_done_d = 1'b0;
      end
    end else begin
      pix_cnt_d    = pix_cnt_q;
      frame_done_d = 1'b0;
    end
  end

  // State register bank. Reset discards any partial fill and any pending output.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fill_q       <= {BUS_W{1'b0}};
      ch_cnt_q     <= {CH_W{1'b0}};
      fill_full_q  <= 1'b0;
      out_q        <= {BUS_W{1'b0}};
      valid_q      <= 1'b0;
      pix_cnt_q    <= {PIX_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      ch_cnt_q     <= ch_cnt_d;
      fill_full_q  <= fill_full_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_layer_2_featuremap_packer.sv
// -----------------------------------------------------------------------------
// Testbench for layer_2_featuremap_packer.
//
// Three instances share one stimulus. They differ only in IMG_SIZE (208, 4
// and 2), so frame boundaries can be observed at several sizes.
//
// The reference model is deliberately simple. Pixel p is the group of
// channel words sent_q[16p .. 16p+15], with word c in lane c. A frame of N
// pixels ends on every N-th output handshake.
// -----------------------------------------------------------------------------
module tb_layer_2_featuremap_packer;

  localparam int DW = 32;
  localparam int NC = 16;
  localparam int PW = DW * NC;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;

  logic          ready_out,  valid_out,  frame_done;
  logic          ready_out4, valid_out4, frame_done4;
  logic          ready_out2, valid_out2, frame_done2;
  logic [PW-1:0] data_out, data_out4, data_out2;

  always #5 Clk = ~Clk;

  layer_2_featuremap_packer #(.DATA_WIDTH(DW), .NUM_CH(NC), .IMG_SIZE(208)) u_dut (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .frame_done(frame_done));

  layer_2_featuremap_packer #(.DATA_WIDTH(DW), .NUM_CH(NC), .IMG_SIZE(4)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out4),
    .data_out(data_out4), .valid_out(valid_out4), .ready_in(ready_in), .frame_done(frame_done4));

  layer_2_featuremap_packer #(.DATA_WIDTH(DW), .NUM_CH(NC), .IMG_SIZE(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out2),
    .data_out(data_out2), .valid_out(valid_out2), .ready_in(ready_in), .frame_done(frame_done2));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit ro_low_seen;

  logic [DW-1:0] sent_q[$];
  logic [PW-1:0] fire_data_q[$];
  int            fire_cyc_q[$];
  int            acc_cyc_q[$];
  int            fd_cyc_q[$];
  int            fd4_cyc_q[$];
  int            fd2_cyc_q[$];

  // Event log: records the edge index of every accept and fire, plus every cycle each frame_done is high
  always @(posedge Clk) begin
    if (Rst === 1'b1) begin
      if (valid_in && ready_out) acc_cyc_q.push_back(cyc);
      if (valid_out && ready_in) begin
        fire_data_q.push_back(data_out);
        fire_cyc_q.push_back(cyc);
      end
      if (frame_done)  fd_cyc_q.push_back(cyc);
      if (frame_done4) fd4_cyc_q.push_back(cyc);
      if (frame_done2) fd2_cyc_q.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  function automatic logic [PW-1:0] model_pixel(input int p);
    logic [PW-1:0] w;
    w = '0;
    for (int c = 0; c < NC; c++) w[c*DW +: DW] = sent_q[p*NC + c];
    return w;
  endfunction

  task automatic clear_logs();
    sent_q.delete();
    fire_data_q.delete();
    fire_cyc_q.delete();
    acc_cyc_q.delete();
    fd_cyc_q.delete();
    fd4_cyc_q.delete();
    fd2_cyc_q.delete();
    ro_low_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    clear_logs();
  endtask

  // Offer one word and hold it until ready_out is seen high. Optionally jitter ready_in.
  task automatic send_word(input logic [DW-1:0] w, input bit rand_rdy);
    int guard;
    guard = 0;
    @(negedge Clk);
    valid_in = 1'b1;
    data_in  = w;
    if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
    #1;
    while (!ready_out && guard < 200) begin
      ro_low_seen = 1'b1;
      @(negedge Clk);
      if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
      #1;
      guard++;
    end
    if (!ready_out) begin
      checks++; failures++;
      $display("FAIL send_word_timeout ready_out=%0b required=1", ready_out);
    end else begin
      sent_q.push_back(w);
    end
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    repeat (n) begin
      @(negedge Clk);
      valid_in = 1'b0;
      data_in  = $urandom;
      if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_fires(input int n, input int budget);
    int k;
    k = 0;
    @(negedge Clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    while (fire_data_q.size() < n && k < budget) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if ({valid_out, valid_out4, valid_out2} !== 3'b000) begin
      failures++; $display("FAIL reset_valid_out got=%b required=000", {valid_out, valid_out4, valid_out2});
    end
    checks++;
    if ({frame_done, frame_done4, frame_done2} !== 3'b000) begin
      failures++; $display("FAIL reset_frame_done got=%b required=000", {frame_done, frame_done4, frame_done2});
    end
    checks++;
    if ({ready_out, ready_out4, ready_out2} !== 3'b111) begin
      failures++; $display("FAIL reset_ready_out got=%b required=111", {ready_out, ready_out4, ready_out2});
    end
    checks++;
    if (data_out !== '0) begin
      failures++; $display("FAIL reset_data_out got=%h required=0", data_out);
    end
    @(negedge Clk);
    Rst = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_pixel();
    logic [PW-1:0] exp_w;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < NC; i++) send_word(32'h3F80_0000 + DW'(i), 1'b0);
    idle(1, 1'b0);
    wait_fires(1, 20);
    idle(4, 1'b0);
    #1;
    checks++;
    if (fire_data_q.size() != 1) begin
      failures++; $display("FAIL single_fire_count got=%0d required=1", fire_data_q.size());
    end else begin
      exp_w = '0;
      for (int c = 0; c < NC; c++) exp_w[c*DW +: DW] = 32'h3F80_0000 + DW'(c);
      checks++;
      if (fire_data_q[0] !== exp_w) begin
        failures++; $display("FAIL single_data got=%h required=%h", fire_data_q[0], exp_w);
      end
      checks++;
      if (acc_cyc_q.size() != NC || fire_cyc_q[0] != acc_cyc_q[NC-1] + 2) begin
        failures++; $display("FAIL single_latency got_fire_edge=%0d required=%0d", fire_cyc_q[0], acc_cyc_q[acc_cyc_q.size()-1] + 2);
      end
    end
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL single_valid_drop got=%b required=0", valid_out);
    end
    checks++;
    if (ro_low_seen) begin
      failures++; $display("FAIL single_ready_out got=dropped required=always_1");
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 2*NC; i++) send_word($urandom, 1'b0);
    // Offer stray words while stalled; none of them may be taken.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      valid_in = 1'b1;
      data_in  = $urandom;
    end
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      failures++; $display("FAIL bp_ready_out got=%b required=0", ready_out);
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== model_pixel(0)) begin
      failures++; $display("FAIL bp_hold_A valid=%b got=%h required=%h", valid_out, data_out, model_pixel(0));
    end
    @(negedge Clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge Clk);
    ready_in = 1'b0;
    #1;
    checks++;
    if (fire_data_q.size() != 1) begin
      failures++; $display("FAIL bp_one_fire got=%0d required=1", fire_data_q.size());
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== model_pixel(1)) begin
      failures++; $display("FAIL bp_B_next valid=%b got=%h required=%h", valid_out, data_out, model_pixel(1));
    end
    checks++;
    if (ready_out !== 1'b1) begin
      failures++; $display("FAIL bp_ready_back got=%b required=1", ready_out);
    end
    ready_in = 1'b1;
    for (int i = 0; i < NC; i++) send_word($urandom, 1'b0);
    wait_fires(3, 60);
    checks++;
    if (fire_data_q.size() != 3) begin
      failures++; $display("FAIL bp_total_fires got=%0d required=3", fire_data_q.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (fire_data_q[p] !== model_pixel(p)) begin
          failures++; $display("FAIL bp_data_%0d got=%h required=%h", p, fire_data_q[p], model_pixel(p));
        end
      end
    end
  endtask

  task automatic test_full_throughput();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 16*NC; i++) send_word($urandom, 1'b0);
    wait_fires(16, 100);
    idle(3, 1'b0);
    checks++;
    if (fire_data_q.size() != 16) begin
      failures++; $display("FAIL tp_fire_count got=%0d required=16", fire_data_q.size());
    end else begin
      for (int p = 0; p < 16; p++) begin
        checks++;
        if (fire_data_q[p] !== model_pixel(p)) begin
          failures++; $display("FAIL tp_data_%0d got=%h required=%h", p, fire_data_q[p], model_pixel(p));
        end
      end
      checks++;
      if (fire_cyc_q[0] != acc_cyc_q[NC-1] + 2) begin
        failures++; $display("FAIL tp_first_latency got=%0d required=%0d", fire_cyc_q[0], acc_cyc_q[NC-1] + 2);
      end
      for (int p = 1; p < 16; p++) begin
        checks++;
        if (fire_cyc_q[p] - fire_cyc_q[p-1] != 16) begin
          failures++; $display("FAIL tp_spacing_%0d got=%0d required=16", p, fire_cyc_q[p] - fire_cyc_q[p-1]);
        end
      end
      checks++;
      if (fd4_cyc_q.size() != 1 || fd4_cyc_q[0] != fire_cyc_q[15] + 1) begin
        failures++; $display("FAIL tp_frame_done4 got_count=%0d required_count=1 at_edge=%0d", fd4_cyc_q.size(), fire_cyc_q[15] + 1);
      end
      checks++;
      if (fd2_cyc_q.size() != 4) begin
        failures++; $display("FAIL tp_frame_done2_count got=%0d required=4", fd2_cyc_q.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (fd2_cyc_q[k] != fire_cyc_q[4*k+3] + 1) begin
            failures++; $display("FAIL tp_frame_done2_%0d got=%0d required=%0d", k, fd2_cyc_q[k], fire_cyc_q[4*k+3] + 1);
          end
        end
      end
    end
    checks++;
    if (fd_cyc_q.size() != 0) begin
      failures++; $display("FAIL tp_frame_done208 got=%0d required=0", fd_cyc_q.size());
    end
    checks++;
    if (u_dut4.pix_cnt_q !== '0) begin
      failures++; $display("FAIL tp_pix_cnt got=%0d required=0", u_dut4.pix_cnt_q);
    end
    checks++;
    if (ro_low_seen) begin
      failures++; $display("FAIL tp_ready_out got=dropped required=always_1");
    end
  endtask

  task automatic test_gapped();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < NC; i++) begin
      send_word(32'hDEAD_BEEF, 1'b0);
      idle(1, 1'b0);
    end
    for (int i = 0; i < NC; i++) begin
      send_word($urandom, 1'b1);
      idle($urandom_range(0, 2), 1'b1);
    end
    wait_fires(2, 100);
    checks++;
    if (acc_cyc_q.size() != 2*NC) begin
      failures++; $display("FAIL gap_accepts got=%0d required=%0d", acc_cyc_q.size(), 2*NC);
    end
    checks++;
    if (fire_data_q.size() != 2) begin
      failures++; $display("FAIL gap_fire_count got=%0d required=2", fire_data_q.size());
    end else begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (fire_data_q[p] !== model_pixel(p)) begin
          failures++; $display("FAIL gap_data_%0d got=%h required=%h", p, fire_data_q[p], model_pixel(p));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < NC + 7; i++) send_word($urandom, 1'b0);
    @(negedge Clk);
    valid_in = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    checks++;
    if ({valid_out, frame_done, ready_out} !== 3'b001) begin
      failures++; $display("FAIL mr_async got=%b required=001", {valid_out, frame_done, ready_out});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      #1;
      checks++;
      if ({valid_out, valid_out4, valid_out2, frame_done, frame_done4, frame_done2} !== 6'b0) begin
        failures++; $display("FAIL mr_held_%0d got=%b required=000000", i, {valid_out, valid_out4, valid_out2, frame_done, frame_done4, frame_done2});
      end
    end
    @(negedge Clk);
    Rst = 1'b1;
    clear_logs();
    ready_in = 1'b1;
    for (int i = 0; i < NC; i++) send_word($urandom, 1'b0);
    wait_fires(1, 20);
    idle(3, 1'b0);
    checks++;
    if (fire_data_q.size() != 1) begin
      failures++; $display("FAIL mr_fire_count got=%0d required=1", fire_data_q.size());
    end else begin
      checks++;
      if (fire_data_q[0] !== model_pixel(0)) begin
        failures++; $display("FAIL mr_data got=%h required=%h", fire_data_q[0], model_pixel(0));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NC; i++) begin
        send_word($urandom, 1'b1);
        idle($urandom_range(0, 1), 1'b1);
      end
    end
    wait_fires(8, 200);
    idle(3, 1'b0);
    checks++;
    if (fire_data_q.size() != 8) begin
      failures++; $display("FAIL wrap_fire_count got=%0d required=8", fire_data_q.size());
    end else begin
      for (int p = 0; p < 8; p++) begin
        checks++;
        if (fire_data_q[p] !== model_pixel(p)) begin
          failures++; $display("FAIL wrap_data_%0d got=%h required=%h", p, fire_data_q[p], model_pixel(p));
        end
      end
      checks++;
      if (fd2_cyc_q.size() != 2) begin
        failures++; $display("FAIL wrap_fd2_count got=%0d required=2", fd2_cyc_q.size());
      end else begin
        checks++;
        if (fd2_cyc_q[0] != fire_cyc_q[3] + 1 || fd2_cyc_q[1] != fire_cyc_q[7] + 1) begin
          failures++; $display("FAIL wrap_fd2_edges got=%0d,%0d required=%0d,%0d", fd2_cyc_q[0], fd2_cyc_q[1], fire_cyc_q[3] + 1, fire_cyc_q[7] + 1);
        end
      end
    end
    checks++;
    if (fd4_cyc_q.size() != 0 || fd_cyc_q.size() != 0) begin
      failures++; $display("FAIL wrap_other_fd got=%0d,%0d required=0,0", fd4_cyc_q.size(), fd_cyc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_full_throughput();
    test_gapped();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
